// File: rtl/pts_pkg.sv
// Shared state encoding and index-width helper for parallel_to_serial_rf.
package pts_pkg;

    typedef enum logic {
        PTS_IDLE = 1'b0,
        PTS_SEND = 1'b1
    } pts_state_e;

    // A single-element word still needs a one-bit index register.
    function automatic int pts_idx_width(input int n_elems);
        int w;
        w = $clog2(n_elems);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/pts_index_counter.sv
// Element index counter: async reset, synchronous clear, advances on en and wraps after MAX.
module pts_index_counter #(
    parameter int MAX = 0,
    parameter int W   = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         en,
    output logic [W-1:0] idx,
    output logic         at_max
);

    logic [W-1:0] idx_q;
    logic [W-1:0] idx_d;

    assign at_max = (idx_q == W'(MAX));
    assign idx    = idx_q;

    always_comb begin
        idx_d = idx_q;
        if (clear) begin
            idx_d = '0;
        end else if (en) begin
            idx_d = at_max ? '0 : idx_q + W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q <= '0;
        end else begin
            idx_q <= idx_d;
        end
    end

endmodule

// File: rtl/parallel_to_serial_rf.sv
// Loads one packed word and streams its elements out one per accepted beat, element 0 first.
// Define PARALLEL_TO_SERIAL_BACK_TO_BACK_EN to accept the next word on the last beat (no bubble).
module parallel_to_serial_rf
    import pts_pkg::*;
#(
    parameter int WIDTH   = 1,
    parameter int N_ELEMS = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [N_ELEMS*WIDTH-1:0]   in,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out,
    output logic                       out_last,
    output logic                       busy
);

    localparam int IDX_W = pts_idx_width(N_ELEMS);

    pts_state_e                 state_q;
    pts_state_e                 state_d;
    logic [N_ELEMS*WIDTH-1:0]   data_q;
    logic [N_ELEMS*WIDTH-1:0]   data_d;
    logic [IDX_W-1:0]           idx;
    logic                       at_max;
    logic                       sending;
    logic                       beat;
    logic                       load;
    logic [WIDTH-1:0]           elem;

    assign sending = (state_q == PTS_SEND);
    assign beat    = sending && out_ready;

    // The index only needs to advance on beats: it is already zero whenever a load can happen.
    pts_index_counter #(
        .MAX (N_ELEMS - 1),
        .W   (IDX_W)
    ) u_idx (
        .clk    (clk),
        .rst    (rst),
        .clear  (clear),
        .en     (beat),
        .idx    (idx),
        .at_max (at_max)
    );

`ifdef PARALLEL_TO_SERIAL_BACK_TO_BACK_EN
    assign in_ready = !clear && ((state_q == PTS_IDLE) || (beat && at_max));
`else
    assign in_ready = !clear && (state_q == PTS_IDLE);
`endif

    assign load = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        if (clear) begin
            state_d = PTS_IDLE;
        end else begin
            if (beat && at_max) begin
                state_d = PTS_IDLE;
            end
            if (load) begin
                state_d = PTS_SEND;
                data_d  = in;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= PTS_IDLE;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        elem = '0;
        for (int i = 0; i < N_ELEMS; i++) begin
            if (idx == IDX_W'(i)) begin
                elem = data_q[i*WIDTH +: WIDTH];
            end
        end
    end

    // Idle output is forced to zero so stray reads stand out.
    assign out_valid = sending;
    assign busy      = sending;
    assign out       = sending ? elem : '0;
    assign out_last  = sending && at_max;

endmodule
